// File: rtl/kulisch_extract_fixed.sv
// -----------------------------------------------------------------------------
// kulisch_extract_fixed
//
// Drains a two's-complement Kulisch accumulator snapshot into sign / exponent /
// fraction form. A snapshot is taken over a valid/ready handshake. The block
// converts it to a magnitude, finds the leading one with an MSB-first scan of
// SCAN_W-bit chunks, and emits the FRAC bits below the hidden leading one
// together with the bit index of that one.
//
// Result value = (-1)^signOut * 1.fracOut * 2^(expOut - ACC_FRAC).
// Zero, inf and overflow inputs bypass the scan and are flagged directly.
//
// Optional feature (compile-time macro):
//   KULISCH_EXTRACT_RNE_EN  defined   -> round to nearest, ties to even
//                           undefined -> truncate the magnitude (toward zero)
// Both builds have identical latency.
//
// Parameters:
//   ACC_NON_FRAC  accumulator integer bits, sign included
//   ACC_FRAC      accumulator fraction bits
//   FRAC          output fraction bits below the hidden one
//   SCAN_W        bits examined per scan cycle; must divide ACC_BITS
//   ACC_BITS must be at least FRAC + 3 so that guard and sticky bits exist.
//
// Ports:
//   clock            rising-edge clock
//   resetn           asynchronous active-low reset
//   inValid/inReady  snapshot handshake; inReady is high only while idle
//   accIn            accumulator, LSB weight 2^-ACC_FRAC
//   accIsInf         accumulator holds inf
//   accIsOverflow    accumulator overflowed
//   accOverflowSign  sign of the overflow
//   outValid/outReady result handshake; outputs hold while outValid is high
//   signOut, expOut, fracOut, zeroOut, infOut  result fields
// -----------------------------------------------------------------------------
module kulisch_extract_fixed #(
  parameter int ACC_NON_FRAC = 8,
  parameter int ACC_FRAC     = 8,
  parameter int FRAC         = 4,
  parameter int SCAN_W       = 4
) (
  input  logic                                         clock,
  input  logic                                         resetn,
  input  logic                                         inValid,
  output logic                                         inReady,
  input  logic [ACC_NON_FRAC+ACC_FRAC-1:0]             accIn,
  input  logic                                         accIsInf,
  input  logic                                         accIsOverflow,
  input  logic                                         accOverflowSign,
  output logic                                         outValid,
  input  logic                                         outReady,
  output logic                                         signOut,
  output logic [$clog2(ACC_NON_FRAC+ACC_FRAC+1)-1:0]   expOut,
  output logic [FRAC-1:0]                              fracOut,
  output logic                                         zeroOut,
  output logic                                         infOut
);

  localparam int ACC_BITS = ACC_NON_FRAC + ACC_FRAC;
  localparam int EXP      = $clog2(ACC_BITS + 1);
  localparam int NCHUNK   = ACC_BITS / SCAN_W;
  localparam int CIDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int POS_W    = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_SCAN,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                state_q, state_d;

  logic [ACC_BITS-1:0]   mag_q;     // raw snapshot, then its magnitude
  logic                  bypass_q;  // zero/inf/overflow: skip the scan
  logic [CIDX_W-1:0]     idx_q;     // chunk currently being scanned
  logic [EXP-1:0]        lead_q;    // bit index of the leading one
  logic                  sign_q;
  logic [EXP-1:0]        exp_q;
  logic [FRAC-1:0]       frac_q;
  logic                  zero_q;
  logic                  inf_q;

  logic                  special;
  logic [SCAN_W-1:0]     chunk;
  logic [POS_W-1:0]      pos;
  logic [EXP-1:0]        scan_lead;
  logic [ACC_BITS-1:0]   norm;
  logic [FRAC-1:0]       frac_t;
  logic                  round_up;
  logic [FRAC:0]         frac_sum;

  assign special = accIsInf | accIsOverflow;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, whatever the order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (inValid)      state_d = S_ABS;
      // Special inputs pass through ABS untouched; this keeps the bypass
      // latency at one cycle after the accept edge.
      S_ABS:   state_d = bypass_q ? S_DONE : S_SCAN;
      S_SCAN:  if (|chunk)       state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (outReady)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan: leading one within the current chunk (highest set bit wins)
  // ---------------------------------------------------------------------------
  always_comb begin
    chunk = mag_q[idx_q*SCAN_W +: SCAN_W];
    pos   = '0;
    for (int j = 0; j < SCAN_W; j++) begin
      if (chunk[j]) pos = POS_W'(j);
    end
    scan_lead = EXP'(int'(idx_q) * SCAN_W + int'(pos));
  end

  // ---------------------------------------------------------------------------
  // Round: left-justify the magnitude so the leading one sits at the MSB.
  // Bits below it are then the fraction, guard and sticky in fixed positions.
  // Fraction bits that fall below bit 0 come in as zeros from the shift.
  // ---------------------------------------------------------------------------
  always_comb begin
    norm   = mag_q << (ACC_BITS - 1 - int'(lead_q));
    frac_t = norm[ACC_BITS-2 -: FRAC];
  end

`ifdef KULISCH_EXTRACT_RNE_EN
  logic guard;
  logic sticky;
  logic unused_norm;

  assign guard       = norm[ACC_BITS-2-FRAC];
  assign sticky      = |norm[ACC_BITS-3-FRAC:0];
  assign round_up    = guard & (sticky | frac_t[0]);
  assign unused_norm = norm[ACC_BITS-1];
`else
  logic unused_norm;

  assign round_up    = 1'b0;
  assign unused_norm = ^{norm[ACC_BITS-1], norm[ACC_BITS-2-FRAC:0]};
`endif

  // A carry out of the fraction leaves the low FRAC bits all zero, so the
  // truncated sum is already the correct fraction and the carry bumps expOut.
  assign frac_sum = {1'b0, frac_t} + {{FRAC{1'b0}}, round_up};

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mag_q    <= '0;
      bypass_q <= 1'b0;
      idx_q    <= '0;
      lead_q   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      frac_q   <= '0;
      zero_q   <= 1'b0;
      inf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (inValid) begin
            mag_q    <= accIn;
            bypass_q <= special | (accIn == '0);
            inf_q    <= special;
            sign_q   <= ~accIsInf & accIsOverflow & accOverflowSign;
            zero_q   <= ~special & (accIn == '0);
            exp_q    <= '0;
            frac_q   <= '0;
          end
        end
        S_ABS: begin
          if (!bypass_q) begin
            sign_q <= mag_q[ACC_BITS-1];
            // The most negative value negates to itself, which read as
            // unsigned is exactly its magnitude.
            mag_q  <= mag_q[ACC_BITS-1] ? -mag_q : mag_q;
            idx_q  <= CIDX_W'(NCHUNK - 1);
          end
        end
        S_SCAN: begin
          if (|chunk) lead_q <= scan_lead;
          else        idx_q  <= idx_q - CIDX_W'(1);
        end
        S_ROUND: begin
          frac_q <= frac_sum[FRAC-1:0];
          exp_q  <= lead_q + EXP'(frac_sum[FRAC]);
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign inReady  = (state_q == S_IDLE);
  assign outValid = (state_q == S_DONE);
  assign signOut  = sign_q;
  assign expOut   = exp_q;
  assign fracOut  = frac_q;
  assign zeroOut  = zero_q;
  assign infOut   = inf_q;

endmodule

// File: tb/tb_kulisch_extract_fixed.sv
// -----------------------------------------------------------------------------
// tb_kulisch_extract_fixed
//
// Self-checking bench for kulisch_extract_fixed at default parameters
// (ACC_BITS = 16, FRAC = 4, SCAN_W = 4). Expected results come from an
// arithmetic model: magnitude, floor(log2), integer scaling and remainder
// comparison for rounding. Follows KULISCH_EXTRACT_RNE_EN like the design.
// -----------------------------------------------------------------------------
module tb_kulisch_extract_fixed;

  localparam int ACC_BITS = 16;
  localparam int FRAC     = 4;
  localparam int SCAN_W   = 4;
  localparam int EXP      = 5;
  localparam int NCHUNK   = ACC_BITS / SCAN_W;
  localparam int MAX_WAIT = 40;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic                inValid = 1'b0;
  logic                inReady;
  logic [ACC_BITS-1:0] accIn = '0;
  logic                accIsInf = 1'b0;
  logic                accIsOverflow = 1'b0;
  logic                accOverflowSign = 1'b0;
  logic                outValid;
  logic                outReady = 1'b0;
  logic                signOut;
  logic [EXP-1:0]      expOut;
  logic [FRAC-1:0]     fracOut;
  logic                zeroOut;
  logic                infOut;

  int checks = 0;
  int errors = 0;

  kulisch_extract_fixed dut (
    .clock           (clock),
    .resetn          (resetn),
    .inValid         (inValid),
    .inReady         (inReady),
    .accIn           (accIn),
    .accIsInf        (accIsInf),
    .accIsOverflow   (accIsOverflow),
    .accOverflowSign (accOverflowSign),
    .outValid        (outValid),
    .outReady        (outReady),
    .signOut         (signOut),
    .expOut          (expOut),
    .fracOut         (fracOut),
    .zeroOut         (zeroOut),
    .infOut          (infOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = acc * 2^-8; result = 1.f * 2^(e-8).
  task automatic ref_model(input logic [ACC_BITS-1:0] acc, input logic inf, input logic ovf,
                           input logic osign, output logic s, output int e, output int f,
                           output logic z, output logic i, output int lat);
    int     v;
    longint m, num, q, r, half2;
    int     p;
    s = 1'b0; e = 0; f = 0; z = 1'b0; i = 1'b0; lat = 1;
    if (inf || ovf) begin
      i = 1'b1;
      s = inf ? 1'b0 : osign;
    end else if (acc == '0) begin
      z = 1'b1;
    end else begin
      v = $signed(acc);
      s = (v < 0);
      m = (v < 0) ? -longint'(v) : longint'(v);
      p = 0;
      while ((m >> (p + 1)) != 0) p++;
      lat = (NCHUNK - p / SCAN_W) + 2;
      num = m << FRAC;
      q   = num >> p;                 // 1.f scaled by 2^FRAC, in [16, 31]
      r   = num - (q << p);
      half2 = longint'(1) << p;
`ifdef KULISCH_EXTRACT_RNE_EN
      if ((2 * r > half2) || ((2 * r == half2) && (q % 2 == 1))) q++;
`else
      if (r < 0 || half2 < 0) q = -1; // unreachable guard keeps r/half2 in use
`endif
      if (q == (longint'(1) << (FRAC + 1))) begin
        q = longint'(1) << FRAC;
        p++;
      end
      e = p;
      f = int'(q) - (1 << FRAC);
    end
  endtask

  // Accept one snapshot, measure latency, check fields, optionally stall the
  // consumer for `hold` cycles (with a competing inValid), then release.
  task automatic run_op(input string tag, input logic [ACC_BITS-1:0] acc, input logic inf,
                        input logic ovf, input logic osign, input int hold);
    logic s, z, i;
    int   e, f, lat, n;
    ref_model(acc, inf, ovf, osign, s, e, f, z, i, lat);

    @(negedge clock);
    check({tag, ".in_ready"}, 32'(inReady), 32'd1);
    inValid         = 1'b1;
    accIn           = acc;
    accIsInf        = inf;
    accIsOverflow   = ovf;
    accOverflowSign = osign;
    @(posedge clock);
    #1;
    // Inputs after the accept edge must be ignored.
    inValid         = 1'b0;
    accIn           = ACC_BITS'($urandom);
    accIsInf        = 1'($urandom);
    accIsOverflow   = 1'($urandom);
    accOverflowSign = 1'($urandom);

    n = 0;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      @(posedge clock);
      #1;
      if (outValid) begin
        n = c;
        break;
      end
    end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    accIsInf      = 1'b0;
    accIsOverflow = 1'b0;
    check({tag, ".sign"}, 32'(signOut), 32'(s));
    check({tag, ".exp"},  32'(expOut),  32'(e));
    check({tag, ".frac"}, 32'(fracOut), 32'(f));
    check({tag, ".zero"}, 32'(zeroOut), 32'(z));
    check({tag, ".inf"},  32'(infOut),  32'(i));

    if (hold > 0) begin
      inValid = 1'b1;
      accIn   = ~acc;
      for (int h = 0; h < hold; h++) begin
        @(posedge clock);
        #1;
        check({tag, ".hold_valid"}, 32'(outValid), 32'd1);
        check({tag, ".hold_ready"}, 32'(inReady), 32'd0);
        check({tag, ".hold_fields"}, {21'd0, signOut, expOut, fracOut, zeroOut, infOut},
              {21'd0, s, EXP'(e), FRAC'(f), z, i});
      end
      inValid = 1'b0;
    end

    @(negedge clock);
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    check({tag, ".released"}, {30'd0, outValid, inReady}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [ACC_BITS-1:0] a;
    int sel;
    int seen;

    // Reset values while resetn is held low.
    repeat (2) @(negedge clock);
    check("reset.in_ready",  32'(inReady),  32'd1);
    check("reset.out_valid", 32'(outValid), 32'd0);
    check("reset.fields", {21'd0, signOut, expOut, fracOut, zeroOut, infOut}, 32'd0);
    resetn = 1'b1;

    // Directed cases.
    run_op("pos_1p5",   16'h0180, 1'b0, 1'b0, 1'b0, 0);
    run_op("neg_1p5",   16'hFE80, 1'b0, 1'b0, 1'b0, 0);
    run_op("most_neg",  16'h8000, 1'b0, 1'b0, 1'b0, 0);
    run_op("zero",      16'h0000, 1'b0, 1'b0, 1'b0, 0);
    run_op("ovf_neg",   16'h1234, 1'b0, 1'b1, 1'b1, 0);
    run_op("inf",       16'h0042, 1'b1, 1'b0, 1'b1, 0);
    run_op("round_fc",  16'h00FC, 1'b0, 1'b0, 1'b0, 0);
    run_op("tie_even",  16'h00F4, 1'b0, 1'b0, 1'b0, 0);
    run_op("lsb_only",  16'h0001, 1'b0, 1'b0, 1'b0, 0);
    run_op("max_pos",   16'h7FFF, 1'b0, 1'b0, 1'b0, 0);
    run_op("minus_one", 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
    run_op("stall",     16'h0DEA, 1'b0, 1'b0, 1'b0, 5);

    // Randomized operations spread over all leading-one positions.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      a   = ACC_BITS'($urandom) >> $urandom_range(0, ACC_BITS - 1);
      if ($urandom_range(0, 1) == 1) a = -a;
      if (sel == 0)      run_op("rnd_zero", 16'h0000, 1'b0, 1'b0, 1'b0, 0);
      else if (sel == 1) run_op("rnd_ovf", a, 1'b0, 1'b1, 1'($urandom), 0);
      else if (sel == 2) run_op("rnd_inf", a, 1'b1, 1'b0, 1'($urandom), 0);
      else               run_op("rnd_val", (a == '0) ? 16'h0003 : a, 1'b0, 1'b0, 1'b0,
                                $urandom_range(0, 2));
    end

    // Reset during SCAN: result discarded, idle immediately.
    @(negedge clock);
    inValid = 1'b1;
    accIn   = 16'h0001;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid.out_valid", 32'(outValid), 32'd0);
    check("rst_mid.in_ready",  32'(inReady),  32'd1);
    check("rst_mid.fields", {21'd0, signOut, expOut, fracOut, zeroOut, infOut}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock);
      #1;
      if (outValid) seen++;
    end
    check("rst_mid.no_result", 32'(seen), 32'd0);

    // Block still works after the abort.
    run_op("post_rst", 16'hFE80, 1'b0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
